// File: rtl/pic_pkg.sv
// Shared 8259A definitions: acknowledge FSM states, level constants and the
// one-hot / index / rotated-priority helpers also used by the PriorityResolver.
package pic_pkg;

  localparam int NUM_IRQ   = 8;
  localparam int RESET_LOW = 7;

  typedef enum logic {IDLE, WAIT2} ack_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] level;
  } scan_t;

  function automatic logic [NUM_IRQ-1:0] index_to_onehot(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction

  function automatic logic [2:0] onehot_to_index(input logic [NUM_IRQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (oh[i]) idx = idx | 3'(i);
    return idx;
  endfunction

  // Lowest set index wins; an empty vector yields level 7 (spurious vector).
  function automatic logic [2:0] lowest_set_index(input logic [NUM_IRQ-1:0] v);
    logic [2:0] idx;
    idx = 3'(RESET_LOW);
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  // Highest priority is the level just above the pointer; scan upward with wrap.
  function automatic scan_t rotated_scan(input logic [NUM_IRQ-1:0] v,
                                         input logic [2:0]         ptr);
    scan_t      r;
    logic [2:0] idx;
    r = '0;
    for (int k = NUM_IRQ; k >= 1; k--) begin
      idx = ptr + 3'(k);
      if (v[idx]) begin
        r.found = 1'b1;
        r.level = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/isr_priority_scan.sv
// Combinational search of the In-Service Register for the highest-priority set
// level, given the one-hot lowest-priority pointer.
module isr_priority_scan
  import pic_pkg::*;
(
  input  logic [NUM_IRQ-1:0] isr_i,
  input  logic [NUM_IRQ-1:0] pointer_i,
  output logic               found_o,
  output logic [2:0]         level_o
);

  scan_t scan;

  assign scan    = rotated_scan(isr_i, onehot_to_index(pointer_i));
  assign found_o = scan.found;
  assign level_o = scan.level;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8086 two-pulse INTA sequencer, ISR owner and rotation pointer for the 8259A.
// Define PIC_ROTATION_EN to enable priority rotation on EOI / AEOI.
module interrupt_ack_sequencer
  import pic_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] interrupt,
  input  logic               inta_strobe,
  input  logic               auto_eoi,
  input  logic               rotate_in_aeoi,
  input  logic               eoi_nonspecific,
  input  logic               eoi_specific,
  input  logic               eoi_rotate,
  input  logic [2:0]         eoi_level,
  input  logic [4:0]         vector_base,
  output logic               int_out,
  output logic [NUM_IRQ-1:0] in_service_register,
  output logic [NUM_IRQ-1:0] highest_level_in_service,
  output logic [NUM_IRQ-1:0] irr_clear,
  output logic [7:0]         data_out,
  output logic               data_out_valid,
  output logic               ack_busy
);

  localparam logic [NUM_IRQ-1:0] PTR_RESET = 8'(1) << RESET_LOW;

  ack_state_t         state_q, state_d;
  logic               int_out_q, int_out_d;
  logic [2:0]         lvl_q, lvl_d;
  logic               spurious_q, spurious_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] ptr_q, ptr_d;
  logic [NUM_IRQ-1:0] irr_clear_q, irr_clear_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               data_out_valid_q, data_out_valid_d;
  logic               ack_busy_q, ack_busy_d;

  logic [NUM_IRQ-1:0] set_mask, aeoi_clr, eoi_clr;
  logic               scan_found;
  logic [2:0]         scan_level;

  isr_priority_scan u_scan (
    .isr_i     (isr_q),
    .pointer_i (ptr_q),
    .found_o   (scan_found),
    .level_o   (scan_level)
  );

`ifndef PIC_ROTATION_EN
  logic unused_rotation;
  assign unused_rotation = rotate_in_aeoi ^ eoi_rotate;
`endif

  // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d          = state_q;
    int_out_d        = int_out_q;
    lvl_d            = lvl_q;
    spurious_d       = spurious_q;
    ptr_d            = ptr_q;
    irr_clear_d      = '0;
    data_out_d       = data_out_q;
    data_out_valid_d = 1'b0;
    ack_busy_d       = ack_busy_q;
    set_mask         = '0;
    aeoi_clr         = '0;
    eoi_clr          = '0;

    unique case (state_q)
      IDLE: begin
        int_out_d = |interrupt;
        if (inta_strobe) begin
          lvl_d       = lowest_set_index(interrupt);
          spurious_d  = (interrupt == '0);
          int_out_d   = 1'b0;
          ack_busy_d  = 1'b1;
          state_d     = WAIT2;
          if (interrupt != '0) set_mask = index_to_onehot(lvl_d);
          irr_clear_d = set_mask;
        end
      end
      WAIT2: begin
        int_out_d = 1'b0;
        if (inta_strobe) begin
          data_out_d       = {vector_base, lvl_q};
          data_out_valid_d = 1'b1;
          ack_busy_d       = 1'b0;
          state_d          = IDLE;
          if (auto_eoi && !spurious_q) begin
            aeoi_clr = index_to_onehot(lvl_q);
`ifdef PIC_ROTATION_EN
            if (rotate_in_aeoi) ptr_d = index_to_onehot(lvl_q);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Evaluated after AEOI so an EOI pointer update takes precedence.
    if (eoi_specific) begin
      eoi_clr = index_to_onehot(eoi_level);
`ifdef PIC_ROTATION_EN
      if (eoi_rotate) ptr_d = index_to_onehot(eoi_level);
`endif
    end else if (eoi_nonspecific && scan_found) begin
      eoi_clr = index_to_onehot(scan_level);
`ifdef PIC_ROTATION_EN
      if (eoi_rotate) ptr_d = index_to_onehot(scan_level);
`endif
    end

    isr_d = (isr_q & ~aeoi_clr & ~eoi_clr) | set_mask;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      int_out_q        <= 1'b0;
      lvl_q            <= 3'(RESET_LOW);
      spurious_q       <= 1'b0;
      isr_q            <= '0;
      ptr_q            <= PTR_RESET;
      irr_clear_q      <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      ack_busy_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      int_out_q        <= int_out_d;
      lvl_q            <= lvl_d;
      spurious_q       <= spurious_d;
      isr_q            <= isr_d;
      ptr_q            <= ptr_d;
      irr_clear_q      <= irr_clear_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      ack_busy_q       <= ack_busy_d;
    end
  end

  assign int_out                  = int_out_q;
  assign in_service_register      = isr_q;
  assign highest_level_in_service = ptr_q;
  assign irr_clear                = irr_clear_q;
  assign data_out                 = data_out_q;
  assign data_out_valid           = data_out_valid_q;
  assign ack_busy                 = ack_busy_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed scenarios plus randomized traffic against a level-based reference
// model of the INTA sequencer; honours PIC_ROTATION_EN like the design.
module tb_interrupt_ack_sequencer;

`ifdef PIC_ROTATION_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] interrupt;
  logic       inta_strobe, auto_eoi, rotate_in_aeoi;
  logic       eoi_nonspecific, eoi_specific, eoi_rotate;
  logic [2:0] eoi_level;
  logic [4:0] vector_base;
  logic       int_out, data_out_valid, ack_busy;
  logic [7:0] in_service_register, highest_level_in_service, irr_clear, data_out;

  int checks = 0;
  int errors = 0;

  interrupt_ack_sequencer dut (
    .clk                      (clk),
    .reset                    (reset),
    .interrupt                (interrupt),
    .inta_strobe              (inta_strobe),
    .auto_eoi                 (auto_eoi),
    .rotate_in_aeoi           (rotate_in_aeoi),
    .eoi_nonspecific          (eoi_nonspecific),
    .eoi_specific             (eoi_specific),
    .eoi_rotate               (eoi_rotate),
    .eoi_level                (eoi_level),
    .vector_base              (vector_base),
    .int_out                  (int_out),
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service),
    .irr_clear                (irr_clear),
    .data_out                 (data_out),
    .data_out_valid           (data_out_valid),
    .ack_busy                 (ack_busy)
  );

  always #5 clk = ~clk;

  // Reference model: ISR as an array of flags, pointer as a level number.
  bit m_isr[8];
  int m_ptr;
  bit m_busy;
  int m_lvl;
  bit m_spur;
  bit m_int;
  int m_irr;
  int m_dout;
  bit m_dval;

  function automatic bit [7:0] exp_isr();
    bit [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) if (m_isr[i]) v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit [7:0] level_bit(input int lvl);
    bit [7:0] v;
    v = '0;
    if (lvl >= 0) v[lvl] = 1'b1;
    return v;
  endfunction

  task automatic model_step();
    bit old_isr[8];
    int old_ptr, new_ptr, set_lvl, hit;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_isr[i] = 1'b0;
      m_ptr = 7; m_busy = 0; m_int = 0; m_irr = -1; m_dout = 0; m_dval = 0;
      m_lvl = 7; m_spur = 0;
      return;
    end
    old_isr = m_isr;
    old_ptr = m_ptr;
    new_ptr = m_ptr;
    set_lvl = -1;
    m_irr   = -1;
    m_dval  = 0;
    if (!m_busy) begin
      m_int = (interrupt != 0);
      if (inta_strobe) begin
        m_lvl = 7; m_spur = 1;
        for (int i = 7; i >= 0; i--) if (interrupt[i]) begin m_lvl = i; m_spur = 0; end
        m_int = 0; m_busy = 1;
        if (!m_spur) begin set_lvl = m_lvl; m_irr = m_lvl; end
      end
    end else begin
      m_int = 0;
      if (inta_strobe) begin
        m_dout = int'(vector_base) * 8 + m_lvl;
        m_dval = 1; m_busy = 0;
        if (auto_eoi && !m_spur) begin
          m_isr[m_lvl] = 0;
          if (ROT_EN && rotate_in_aeoi) new_ptr = m_lvl;
        end
      end
    end
    if (eoi_specific) begin
      m_isr[eoi_level] = 0;
      if (ROT_EN && eoi_rotate) new_ptr = int'(eoi_level);
    end else if (eoi_nonspecific) begin
      hit = -1;
      for (int k = 8; k >= 1; k--) if (old_isr[(old_ptr + k) % 8]) hit = (old_ptr + k) % 8;
      if (hit >= 0) begin
        m_isr[hit] = 0;
        if (ROT_EN && eoi_rotate) new_ptr = hit;
      end
    end
    if (set_lvl >= 0) m_isr[set_lvl] = 1;
    m_ptr = new_ptr;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    interrupt = '0; inta_strobe = 0; auto_eoi = 0; rotate_in_aeoi = 0;
    eoi_nonspecific = 0; eoi_specific = 0; eoi_rotate = 0; eoi_level = '0;
    vector_base = 5'b01000;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; tick(); tick();
    reset = 0;
  endtask

  task automatic inta_pulse();
    inta_strobe = 1; tick(); inta_strobe = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    interrupt = 8'hff; inta_strobe = 1; eoi_specific = 1;
    reset = 1; tick(); tick();
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL reset_int_out got %0b exp 0", int_out); end
    checks++; if (in_service_register !== 8'h00) begin errors++; $display("FAIL reset_isr got %h exp 00", in_service_register); end
    checks++; if (highest_level_in_service !== 8'h80) begin errors++; $display("FAIL reset_ptr got %h exp 80", highest_level_in_service); end
    checks++; if (irr_clear !== 8'h00) begin errors++; $display("FAIL reset_irr_clear got %h exp 00", irr_clear); end
    checks++; if (data_out !== 8'h00 || data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_data got %h/%0b exp 00/0", data_out, data_out_valid); end
    checks++; if (ack_busy !== 1'b0) begin errors++; $display("FAIL reset_ack_busy got %0b exp 0", ack_busy); end
    reset = 0;
    idle_inputs();
  endtask

  task automatic test_basic_ack();
    do_reset();
    interrupt = 8'b0001_0000;
    tick();
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL ack_int_raise got %0b exp 1", int_out); end
    inta_pulse();
    checks++; if (irr_clear !== 8'h10) begin errors++; $display("FAIL ack_irr_clear got %h exp 10", irr_clear); end
    checks++; if (in_service_register !== 8'h10) begin errors++; $display("FAIL ack_isr got %h exp 10", in_service_register); end
    checks++; if (int_out !== 1'b0 || ack_busy !== 1'b1) begin errors++; $display("FAIL ack_first got int %0b busy %0b exp 0 1", int_out, ack_busy); end
    tick();
    checks++; if (irr_clear !== 8'h00 || int_out !== 1'b0) begin errors++; $display("FAIL ack_wait2 got irr %h int %0b exp 00 0", irr_clear, int_out); end
    inta_pulse();
    checks++; if (data_out !== 8'h44 || data_out_valid !== 1'b1 || ack_busy !== 1'b0) begin
      errors++; $display("FAIL ack_vector got %h v%0b busy %0b exp 44 v1 busy 0", data_out, data_out_valid, ack_busy); end
    interrupt = '0;
    tick();
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL ack_valid_pulse got %0b exp 0", data_out_valid); end
  endtask

  task automatic test_nonspecific_eoi();
    do_reset();
    interrupt = 8'h10; tick(); inta_pulse(); interrupt = '0; inta_pulse();
    interrupt = 8'h02; tick(); inta_pulse(); interrupt = '0; inta_pulse();
    checks++; if (in_service_register !== 8'h12 || highest_level_in_service !== 8'h80) begin
      errors++; $display("FAIL ns_setup got isr %h ptr %h exp 12 80", in_service_register, highest_level_in_service); end
    eoi_nonspecific = 1; eoi_rotate = 1; tick(); eoi_nonspecific = 0; eoi_rotate = 0;
    checks++; if (in_service_register !== 8'h10) begin errors++; $display("FAIL ns_eoi_isr got %h exp 10", in_service_register); end
    checks++; if (highest_level_in_service !== (ROT_EN ? 8'h02 : 8'h80)) begin
      errors++; $display("FAIL ns_eoi_ptr got %h exp %h", highest_level_in_service, ROT_EN ? 8'h02 : 8'h80); end
  endtask

  task automatic test_spurious();
    do_reset();
    vector_base = 5'b10101;
    inta_pulse();
    checks++; if (in_service_register !== 8'h00 || irr_clear !== 8'h00 || ack_busy !== 1'b1) begin
      errors++; $display("FAIL spur_first got isr %h irr %h busy %0b exp 00 00 1", in_service_register, irr_clear, ack_busy); end
    inta_pulse();
    checks++; if (data_out !== 8'b10101_111 || data_out_valid !== 1'b1) begin
      errors++; $display("FAIL spur_vector got %h v%0b exp af v1", data_out, data_out_valid); end
  endtask

  task automatic test_aeoi();
    do_reset();
    auto_eoi = 1; rotate_in_aeoi = 1; interrupt = 8'h08;
    tick(); inta_pulse();
    checks++; if (in_service_register !== 8'h08) begin errors++; $display("FAIL aeoi_set got %h exp 08", in_service_register); end
    interrupt = '0;
    inta_pulse();
    checks++; if (in_service_register !== 8'h00) begin errors++; $display("FAIL aeoi_clear got %h exp 00", in_service_register); end
    checks++; if (highest_level_in_service !== (ROT_EN ? 8'h08 : 8'h80)) begin
      errors++; $display("FAIL aeoi_ptr got %h exp %h", highest_level_in_service, ROT_EN ? 8'h08 : 8'h80); end
    auto_eoi = 0; rotate_in_aeoi = 0;
  endtask

  task automatic test_reset_mid_inta();
    do_reset();
    interrupt = 8'h04; tick(); inta_pulse();
    reset = 1; tick(); reset = 0;
    checks++; if (in_service_register !== 8'h00 || ack_busy !== 1'b0 || highest_level_in_service !== 8'h80 || data_out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid got isr %h busy %0b ptr %h v%0b exp 00 0 80 v0",
                         in_service_register, ack_busy, highest_level_in_service, data_out_valid); end
    inta_pulse();
    checks++; if (ack_busy !== 1'b1 || data_out_valid !== 1'b0 || in_service_register !== 8'h04) begin
      errors++; $display("FAIL rst_mid_first got busy %0b v%0b isr %h exp 1 v0 04", ack_busy, data_out_valid, in_service_register); end
    interrupt = '0;
    inta_pulse();
    checks++; if (data_out !== 8'h42 || data_out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_vector got %h v%0b exp 42 v1", data_out, data_out_valid); end
  endtask

  task automatic test_set_vs_eoi();
    do_reset();
    interrupt = 8'h04; tick();
    inta_strobe = 1; eoi_specific = 1; eoi_level = 3'd2; tick();
    inta_strobe = 0; eoi_specific = 0;
    checks++; if (in_service_register[2] !== 1'b1) begin errors++; $display("FAIL set_wins got %h exp bit2 set", in_service_register); end
    interrupt = '0;
    inta_pulse();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      reset           = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 3))
        0, 1:    interrupt = '0;
        2:       interrupt = 8'(1) << $urandom_range(0, 7);
        default: interrupt = 8'($urandom);
      endcase
      inta_strobe     = ($urandom_range(0, 3) == 0);
      auto_eoi        = ($urandom_range(0, 1) == 0);
      rotate_in_aeoi  = ($urandom_range(0, 1) == 0);
      eoi_nonspecific = ($urandom_range(0, 5) == 0);
      eoi_specific    = ($urandom_range(0, 7) == 0);
      eoi_rotate      = ($urandom_range(0, 1) == 0);
      eoi_level       = 3'($urandom);
      vector_base     = 5'($urandom);
      tick();
      checks++; if (int_out !== m_int) begin errors++; $display("FAIL rand_int_out cyc %0d got %0b exp %0b", c, int_out, m_int); end
      checks++; if (in_service_register !== exp_isr()) begin errors++; $display("FAIL rand_isr cyc %0d got %h exp %h", c, in_service_register, exp_isr()); end
      checks++; if (highest_level_in_service !== level_bit(m_ptr)) begin errors++; $display("FAIL rand_ptr cyc %0d got %h exp %h", c, highest_level_in_service, level_bit(m_ptr)); end
      checks++; if (irr_clear !== level_bit(m_irr)) begin errors++; $display("FAIL rand_irr_clear cyc %0d got %h exp %h", c, irr_clear, level_bit(m_irr)); end
      checks++; if (data_out !== 8'(m_dout)) begin errors++; $display("FAIL rand_data_out cyc %0d got %h exp %h", c, data_out, 8'(m_dout)); end
      checks++; if (data_out_valid !== m_dval) begin errors++; $display("FAIL rand_valid cyc %0d got %0b exp %0b", c, data_out_valid, m_dval); end
      checks++; if (ack_busy !== m_busy) begin errors++; $display("FAIL rand_ack_busy cyc %0d got %0b exp %0b", c, ack_busy, m_busy); end
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_basic_ack();
    test_nonspecific_eoi();
    test_spurious();
    test_aeoi();
    test_reset_mid_inta();
    test_set_vs_eoi();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
